// File: rtl/act_unpacker.sv
// -----------------------------------------------------------------------------
// act_unpacker
//
// Expands packed activation words read from activation memory into full-width
// signed lane vectors for the PE-array input buffer. One packed word produces
// 1, 2 or 4 beats for 8-, 4- or 2-bit precision. This is the exact inverse of
// the packer after the PE array, for both the FC/EWS and CNN lane layouts.
//
// Ports
//   clk        in   clock
//   reset      in   asynchronous, active-low reset
//   clear      in   synchronous flush of the held word and beat counter
//   precision  in   0 = 8b, 1 = 4b, 2 = 2b, 3 = 8b (sampled at accept)
//   mode       in   MODE_CNN selects the CNN layout, else FC/EWS (sampled at accept)
//   in_valid   in   packed word valid
//   in_ready   out  a word can be accepted this cycle
//   in_data    in   packed word, byte k = in_data[8k+7:8k]
//   out_valid  out  out_data holds a beat
//   out_ready  in   consumer takes the beat
//   out_data   out  N signed lanes, lane m = out_data[8m+7:8m]
//   out_beat   out  index of the current beat within its word
//   out_last   out  current beat is the last beat of its word
//
// Lane slices are ACT_W bits wide; sub-byte fields live in the low 8 bits of
// each slice, so ACT_W must be at least 8. N_DIM_ARRAY must be a multiple of 4.
// -----------------------------------------------------------------------------
module act_unpacker #(
  parameter int         N_DIM_ARRAY = 8,
  parameter int         ACT_W       = 8,
  parameter logic [2:0] MODE_CNN    = 3'd1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [1:0]                   precision,
  input  logic [2:0]                   mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ACT_W*N_DIM_ARRAY-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACT_W*N_DIM_ARRAY-1:0] out_data,
  output logic [1:0]                   out_beat,
  output logic                         out_last
);

  localparam int W     = ACT_W * N_DIM_ARRAY;
  localparam int HALF  = N_DIM_ARRAY / 2;
  localparam int QUART = N_DIM_ARRAY / 4;

  logic [W-1:0] r_word;
  logic [1:0]   r_prec;
  logic         r_cnn;
  logic [1:0]   r_beat;
  logic         r_full;

  logic         w_last;
  logic         w_accept;
  logic         w_consume;
  logic [W-1:0] w_data;

  // Two's-complement sign extension of a 4-bit field to a full lane.
  function automatic logic signed [ACT_W-1:0] sext4(input logic [3:0] v);
    return {{(ACT_W-4){v[3]}}, v};
  endfunction

  // Two's-complement sign extension of a 2-bit field to a full lane.
  function automatic logic signed [ACT_W-1:0] sext2(input logic [1:0] v);
    return {{(ACT_W-2){v[1]}}, v};
  endfunction

  // Produces lane m of the given beat from the held word.
  // FC packs neighbouring lanes into the same byte and walks the bytes beat by
  // beat; CNN keeps lane m in byte m and walks the fields inside the byte.
  function automatic logic signed [ACT_W-1:0] decode_lane(
    input logic [W-1:0] word,
    input logic [1:0]   prec,
    input logic         cnn,
    input logic [1:0]   beat,
    input int           m
  );
    logic signed [ACT_W-1:0] lane;
    logic [ACT_W-1:0]        b8;
    logic [3:0]              nib;
    logic [1:0]              fld;
    int                      idx;
    int                      f;
    lane = '0;
    b8   = '0;
    nib  = '0;
    fld  = '0;
    idx  = m;
    f    = 0;
    case (prec)
      2'd1: begin
        if (cnn) begin
          idx = m;
          f   = int'(beat[0]);
        end else begin
          idx = int'(beat[0]) * HALF + m / 2;
          f   = m % 2;
        end
        b8   = word[idx*ACT_W +: ACT_W];
        nib  = (f != 0) ? b8[7:4] : b8[3:0];
        lane = sext4(nib);
      end
      2'd2: begin
        if (cnn) begin
          idx = m;
          f   = int'(beat);
        end else begin
          idx = int'(beat) * QUART + m / 4;
          f   = m % 4;
        end
        b8   = word[idx*ACT_W +: ACT_W];
        fld  = b8[2*f +: 2];
        lane = sext2(fld);
      end
      default: begin
        lane = word[m*ACT_W +: ACT_W];
      end
    endcase
    return lane;
  endfunction

  // Last beat of the held word: beat nb-1 for the latched precision.
  always_comb begin
    w_last = 1'b0;
    case (r_prec)
      2'd1:    w_last = (r_beat == 2'd1);
      2'd2:    w_last = (r_beat == 2'd3);
      default: w_last = (r_beat == 2'd0);
    endcase
  end

  // A new word can enter when empty or when the final beat leaves this cycle;
  // clear blocks any accept so a flushed cycle never loads a word.
  assign in_ready  = !clear && (!r_full || (out_ready && w_last));
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_full && out_ready;

  // Holding stage: word, latched format and beat position
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word <= '0;
      r_prec <= 2'd0;
      r_cnn  <= 1'b0;
      r_beat <= 2'd0;
      r_full <= 1'b0;
    end else if (clear) begin
      r_full <= 1'b0;
      r_beat <= 2'd0;
    end else if (w_accept) begin
      // Accept only fires with the buffer empty or its last beat leaving,
      // so loading here also covers the back-to-back case.
      r_word <= in_data;
      r_prec <= precision;
      r_cnn  <= (mode == MODE_CNN);
      r_beat <= 2'd0;
      r_full <= 1'b1;
    end else if (w_consume) begin
      if (w_last) begin
        r_full <= 1'b0;
        r_beat <= 2'd0;
      end else begin
        r_beat <= r_beat + 2'd1;
      end
    end
  end

  // Output stage: combinational decode straight from the holding register
  always_comb begin
    w_data = '0;
    for (int m = 0; m < N_DIM_ARRAY; m++) begin
      w_data[m*ACT_W +: ACT_W] = decode_lane(r_word, r_prec, r_cnn, r_beat, m);
    end
  end

  assign out_valid = r_full;
  assign out_data  = w_data;
  assign out_beat  = r_beat;
  assign out_last  = w_last;

endmodule

// File: tb/tb_act_unpacker.sv
// -----------------------------------------------------------------------------
// tb_act_unpacker
//
// Directed bench for act_unpacker with N_DIM_ARRAY = 8, ACT_W = 8 and the
// default MODE_CNN encoding (3'd1). Expected lane vectors are hand-derived
// constants; lane 0 is the least significant byte of each constant.
// -----------------------------------------------------------------------------
module tb_act_unpacker;

  localparam int N = 8;
  localparam int A = 8;
  localparam logic [2:0] M_FC  = 3'd0;
  localparam logic [2:0] M_CNN = 3'd1;

  logic            clk;
  logic            reset;
  logic            clear;
  logic [1:0]      precision;
  logic [2:0]      mode;
  logic            in_valid;
  logic            in_ready;
  logic [N*A-1:0]  in_data;
  logic            out_valid;
  logic            out_ready;
  logic [N*A-1:0]  out_data;
  logic [1:0]      out_beat;
  logic            out_last;

  int n_checks;
  int n_pass;

  act_unpacker #(
    .N_DIM_ARRAY(N),
    .ACT_W      (A),
    .MODE_CNN   (M_CNN)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .precision(precision),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_beat (out_beat),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  logic [63:0] w8 [3];
  logic [63:0] w4;
  logic [63:0] w4_b0;
  logic [63:0] w4_b1;
  logic [63:0] w2cnn_b [4];
  logic [63:0] w2fc;
  logic [63:0] w2fc_b [4];
  logic [63:0] w8n;

  initial begin
    n_checks = 0;
    n_pass   = 0;

    w8[0] = 64'h40302010FE017F80;
    w8[1] = 64'h0123456789ABCDEF;
    w8[2] = 64'hFFFF0000A5A55A5A;
    w4    = 64'h0FEDCBA987654321;
    w4_b0 = 64'hF807060504030201;
    w4_b1 = 64'h00FFFEFDFCFBFAF9;
    w2cnn_b[0] = 64'h0000000000000000;
    w2cnn_b[1] = 64'h0101010101010101;
    w2cnn_b[2] = 64'hFEFEFEFEFEFEFEFE;
    w2cnn_b[3] = 64'hFFFFFFFFFFFFFFFF;
    w2fc       = 64'h400CFF00AA551BE4;
    w2fc_b[0]  = 64'h0001FEFFFFFE0100;
    w2fc_b[1]  = 64'hFEFEFEFE01010101;
    w2fc_b[2]  = 64'hFFFFFFFF00000000;
    w2fc_b[3]  = 64'h010000000000FF00;
    w8n        = 64'h8877665544332211;

    reset     = 1'b0;
    clear     = 1'b0;
    precision = 2'd0;
    mode      = M_FC;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset values
    #2;
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data",  out_data,  64'h0);
    chk("rst_out_beat",  out_beat,  2'd0);
    chk("rst_out_last",  out_last,  1'b1);
    #1;
    reset = 1'b1;

    // 1: 8b passthrough, three back-to-back words
    tick();
    in_valid  = 1'b1;
    in_data   = w8[0];
    precision = 2'd0;
    mode      = M_FC;
    out_ready = 1'b1;
    #1;
    chk("t1_idle_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      in_valid = (i < 2);
      in_data  = (i < 2) ? w8[i+1] : 64'h0;
      #1;
      chk($sformatf("t1_valid%0d", i), out_valid, 1'b1);
      chk($sformatf("t1_data%0d", i),  out_data,  w8[i]);
      chk($sformatf("t1_last%0d", i),  out_last,  1'b1);
      chk($sformatf("t1_ready%0d", i), in_ready,  1'b1);
    end
    tick();
    #1;
    chk("t1_drained", out_valid, 1'b0);

    // 2: 4b FC
    in_valid  = 1'b1;
    in_data   = w4;
    precision = 2'd1;
    mode      = M_FC;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("t2_b0_data",  out_data, w4_b0);
    chk("t2_b0_beat",  out_beat, 2'd0);
    chk("t2_b0_last",  out_last, 1'b0);
    chk("t2_b0_ready", in_ready, 1'b0);
    tick();
    #1;
    chk("t2_b1_data",  out_data, w4_b1);
    chk("t2_b1_beat",  out_beat, 2'd1);
    chk("t2_b1_last",  out_last, 1'b1);
    chk("t2_b1_ready", in_ready, 1'b1);
    tick();
    #1;
    chk("t2_drained", out_valid, 1'b0);

    // 3: 2b CNN, all bytes 0xE4
    in_valid  = 1'b1;
    in_data   = 64'hE4E4E4E4E4E4E4E4;
    precision = 2'd2;
    mode      = M_CNN;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      #1;
      chk($sformatf("t3_data%0d", b),  out_data,  w2cnn_b[b]);
      chk($sformatf("t3_beat%0d", b),  out_beat,  b[1:0]);
      chk($sformatf("t3_last%0d", b),  out_last,  (b == 3));
      chk($sformatf("t3_valid%0d", b), out_valid, 1'b1);
      tick();
    end
    #1;
    chk("t3_drained", out_valid, 1'b0);

    // 4: backpressure on a 4b word, then back-to-back accept on beat 1
    in_valid  = 1'b1;
    in_data   = w4;
    precision = 2'd1;
    mode      = M_FC;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("t4_stall_data%0d", s),  out_data, w4_b0);
      chk($sformatf("t4_stall_beat%0d", s),  out_beat, 2'd0);
      chk($sformatf("t4_stall_ready%0d", s), in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("t4_still_b0", out_data, w4_b0);
    tick();
    in_valid = 1'b1;
    in_data  = 64'h1111111111111111;
    #1;
    chk("t4_b1_data",  out_data, w4_b1);
    chk("t4_b1_beat",  out_beat, 2'd1);
    chk("t4_b1_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t4_next_valid", out_valid, 1'b1);
    chk("t4_next_beat",  out_beat,  2'd0);
    chk("t4_next_data",  out_data,  64'h0101010101010101);
    tick();
    #1;
    chk("t4_next_b1", out_data, 64'h0101010101010101);
    chk("t4_next_last", out_last, 1'b1);
    tick();
    #1;
    chk("t4_drained", out_valid, 1'b0);

    // 5: format changes mid-word are ignored, next word uses the new format
    in_valid  = 1'b1;
    in_data   = w2fc;
    precision = 2'd2;
    mode      = M_FC;
    tick();
    in_valid = 1'b0;
    #1;
    chk("t5_b0_data", out_data, w2fc_b[0]);
    precision = 2'd0;
    mode      = M_CNN;
    tick();
    in_valid = 1'b1;
    in_data  = w8n;
    for (int b = 1; b < 4; b++) begin
      #1;
      chk($sformatf("t5_data%0d", b),  out_data, w2fc_b[b]);
      chk($sformatf("t5_beat%0d", b),  out_beat, b[1:0]);
      chk($sformatf("t5_ready%0d", b), in_ready, (b == 3));
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("t5_next_valid", out_valid, 1'b1);
    chk("t5_next_data",  out_data,  w8n);
    chk("t5_next_last",  out_last,  1'b1);
    tick();
    #1;
    chk("t5_drained", out_valid, 1'b0);

    // 6a: clear during beat 1 of a 2b word, with a word offered
    in_valid  = 1'b1;
    in_data   = 64'hE4E4E4E4E4E4E4E4;
    precision = 2'd2;
    mode      = M_CNN;
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    chk("t6_b1_beat", out_beat, 2'd1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = w8n;
    #1;
    chk("t6_clear_ready", in_ready, 1'b0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t6_clear_valid", out_valid, 1'b0);
    chk("t6_clear_beat",  out_beat,  2'd0);
    tick();
    #1;
    chk("t6_clear_stays", out_valid, 1'b0);

    // 6b: asynchronous reset in the middle of a 4b word
    in_valid  = 1'b1;
    in_data   = w4;
    precision = 2'd1;
    mode      = M_FC;
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    chk("t6_pre_rst_beat", out_beat, 2'd1);
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_data",  out_data,  64'h0);
    chk("t6_rst_beat",  out_beat,  2'd0);
    chk("t6_rst_last",  out_last,  1'b1);
    chk("t6_rst_ready", in_ready,  1'b1);
    #1;
    reset = 1'b1;
    tick();
    #1;
    chk("t6_post_rst_idle", out_valid, 1'b0);
    in_valid  = 1'b1;
    in_data   = w8[1];
    precision = 2'd0;
    tick();
    in_valid = 1'b0;
    #1;
    chk("t6_post_rst_data", out_data, w8[1]);
    chk("t6_post_rst_last", out_last, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/act_unpacker.md
# act_unpacker

Reads packed activation words from activation memory and expands them into full-width signed 8-bit lane vectors for the PE-array input buffer (parallel load and serial CNN feed). It is the exact inverse of the output packing performed after the PE array: one packed word yields 1, 2 or 4 beats for 8-, 4- or 2-bit precision. Lane and beat ordering matches the packer for both FC/EWS and CNN modes. It sits between the activation-memory read port and the array's input-buffer load path, with valid/ready on both sides.

## Interface
Parameters:
- N_DIM_ARRAY, 8: number of lanes; must be a multiple of 4.
- ACT_W, 8: lane width in bits; packed word width is ACT_W*N_DIM_ARRAY.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- clear  in  1  synchronous flush of the held word and beat counter.
- precision  in  2  0 = 8b, 1 = 4b, 2 = 2b, 3 = 8b.
- mode  in  3  MODE_CNN selects the per-lane layout; any other value selects the FC/EWS layout.
- in_valid  in  1  packed word valid.
- in_ready  out  1  unpacker can accept a word this cycle.
- in_data  in  ACT_W*N_DIM_ARRAY  packed word; byte k = in_data[8k+7:8k].
- out_valid  out  1  out_data holds a beat.
- out_ready  in  1  consumer takes the beat.
- out_data  out  ACT_W*N_DIM_ARRAY  N signed lanes; lane m = out_data[8m+7:8m].
- out_beat  out  2  index of the current beat within its word.
- out_last  out  1  current beat is the last beat of its word.

## Operation
- Holding register `word_q`, latched `prec_q` and `cnn_q`, beat counter `beat_q[1:0]`, and `full_q`.
- Beats per word: `nb` = 1 (8b), 2 (4b), 4 (2b).
- **Accept.** An accept occurs on `in_valid && in_ready`. It loads `word_q`, `prec_q` and `cnn_q`, sets `beat_q = 0` and sets `full_q = 1`.
  - precision and mode are sampled only at accept. Changes mid-word have no effect on the held word.
- `in_ready = !full_q || (out_ready && out_last)`. This allows back-to-back words with no bubble.
- **Consume.** A consume occurs on `out_valid && out_ready`.
  - If `out_last`: `full_q` clears, unless an accept happens in the same cycle, in which case the new word is loaded.
  - Otherwise `beat_q` increments.
- Outputs: `out_valid = full_q`, `out_beat = beat_q`, `out_last = (beat_q == nb-1)`.
- **Decode, 8b:** lane m = byte m.
- **Decode, 4b FC:** beat b uses bytes `[b*N/2 .. b*N/2+N/2-1]`.
  - Lane 2k comes from byte `b*N/2+k` bits `[3:0]`.
  - Lane 2k+1 comes from bits `[7:4]` of the same byte.
- **Decode, 4b CNN:** lane m = byte m field b (b = 0 → `[3:0]`, b = 1 → `[7:4]`).
- **Decode, 2b FC:** beat b uses bytes `[b*N/4 .. b*N/4+N/4-1]`. Lane 4k+f comes from byte `b*N/4+k` bits `[2f+1:2f]`.
- **Decode, 2b CNN:** lane m = byte m bits `[2b+1:2b]`.
- Every sub-byte field is two's-complement and is sign-extended to ACT_W. Beat 0 is always taken from the lowest-order positions.
- **clear:**
  - `full_q` and `beat_q` go to 0 the next cycle. Any in-flight word is dropped.
  - clear has priority over a simultaneous accept: the word is not loaded and `in_ready` is forced to 0 during clear.
- When `out_valid = 0`, out_data shows the stale decode and must not be sampled.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_beat` = 0, `out_last` = 1 (8b default `prec_q`).
- Latency: a word accepted at edge k is presented from cycle k+1. out_data is combinational from `word_q`/`beat_q`, with no added register.
- Throughput:
  - 1 word/cycle at 8b; 1 word per 2 cycles at 4b; 1 word per 4 cycles at 2b, when `out_ready` is held high.
- `out_ready` low stalls: `beat_q`, `word_q` and all outputs stay stable.
- Mid-operation reset: all state returns to reset values asynchronously, and any partial word is lost.
- A precision change between words takes effect on the next accept without a bubble.

## Test plan
Directed scenarios use N = 8.
1. **8b passthrough.** Stream 3 words with `out_ready` = 1: in_data bytes 0x80, 0x7F, 0x01, … → out_data equals in_data 1 cycle later, `out_last` = 1 every beat, `in_ready` stays 1.
2. **4b FC.** Bytes 0..7 = 0x21, 0x43, 0x65, 0x87, 0xA9, 0xCB, 0xED, 0x0F.
   - Beat 0 lanes = 01, 02, 03, 04, 05, 06, 07, F8.
   - Beat 1 lanes = F9, FA, FB, FC, FD, FE, FF, 00.
   - `out_last` is asserted on beat 1 only; `in_ready` = 0 during beat 0.
3. **2b CNN.** All bytes = 0xE4 → beats 0..3 have every lane = 00, 01, FE, FF; `out_beat` = 0, 1, 2, 3; `out_last` is asserted on beat 3.
4. **Backpressure.** 4b word with `out_ready` low for 3 cycles during beat 0 → beat 0 is held stable and `beat_q` does not advance. Then beat 1 appears, and a next word presented during beat 1 is accepted in the same cycle beat 1 is consumed.
5. **Precision/mode mid-word.**
   - Accept a 2b FC word, then switch precision to 0 and mode to CNN after beat 0 → the remaining 3 beats still decode as 2b FC.
   - The next word then decodes as 8b.
6. **clear and reset.**
   - Assert clear during beat 1 of a 2b word with `in_valid` = 1 → the next cycle has `out_valid` = 0 and the word is not accepted.
   - Drop reset asynchronously mid-word → all outputs return to reset values immediately.
